// File: rtl/stream_skid_slice.sv
// stream_skid_slice
//   Fully registered valid/ready slice for the {data, data2} composite stream.
//   It cuts every combinational path between the two sides: out_valid and
//   out_data/out_data2 come straight from flops, and in_ready is a flop too.
//   Two entries of storage are kept: "main", which drives out_*, and "skid",
//   which catches the beat that is already in flight when the consumer stalls.
//
// Ports
//   clk        in   1            rising-edge clock
//   rst_n      in   1            asynchronous active-low reset
//   in_data    in   DATA_WIDTH   upstream payload, unsigned
//   in_data2   in   DATA2_WIDTH  upstream payload, signed
//   in_valid   in   1            upstream payload valid
//   in_ready   out  1            slice can accept (registered)
//   out_data   out  DATA_WIDTH   downstream payload (registered, main entry)
//   out_data2  out  DATA2_WIDTH  downstream payload, signed (registered, main entry)
//   out_valid  out  1            downstream valid (registered)
//   out_ready  in   1            downstream can accept
//
// Handshake: a beat moves across an interface on a rising edge where its valid
// and ready are both 1. A producer holding valid=1 may not rely on ready to
// withdraw it; this slice never takes a beat while in_valid=0 and never drops
// or changes out_* while out_valid=1 and out_ready=0.

module stream_skid_slice #(
    parameter int DATA_WIDTH  = 16,
    parameter int DATA2_WIDTH = 13
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic signed [DATA2_WIDTH-1:0] in_data2,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic signed [DATA2_WIDTH-1:0] out_data2,
    output logic                          out_valid,
    input  logic                          out_ready
);

    // EMPTY: nothing held. ONE: main holds a beat. FULL: main and skid both hold.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                        state;
    logic [DATA_WIDTH-1:0]         skid_data;
    logic signed [DATA2_WIDTH-1:0] skid_data2;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // out_valid and in_ready are updated alongside the state so that neither
    // is a decode of state; they always equal (state != EMPTY) and
    // (state != FULL) respectively.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            out_data   <= '0;
            out_data2  <= '0;
            skid_data  <= '0;
            skid_data2 <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        out_data  <= in_data;
                        out_data2 <= in_data2;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        // Consumer takes main while a new beat arrives: replace
                        // main directly, skid stays unused.
                        out_data  <= in_data;
                        out_data2 <= in_data2;
                    end else if (in_fire) begin
                        // Consumer stalled but in_ready was already 1 this cycle:
                        // park the arriving beat in skid.
                        skid_data  <= in_data;
                        skid_data2 <= in_data2;
                        in_ready   <= 1'b0;
                        state      <= FULL;
                    end else if (out_fire) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is 0 here, so in_valid has no effect.
                    if (out_fire) begin
                        out_data  <= skid_data;
                        out_data2 <= skid_data2;
                        in_ready  <= 1'b1;
                        state     <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_skid_slice.sv
// Testbench for stream_skid_slice. The reference is a two-deep queue of
// {data, data2} words: a beat enters when in_valid=1 and fewer than two are
// held, the head leaves when out_ready=1 and at least one is held. A negedge
// compare process checks the DUT against that queue every cycle; directed
// phases add literal expectations.

module tb_stream_skid_slice;

    localparam int DW  = 16;
    localparam int D2W = 13;
    localparam int RAND_BEATS = 10000;

    logic                  clk;
    logic                  rst_n;
    logic [DW-1:0]         in_data;
    logic signed [D2W-1:0] in_data2;
    logic                  in_valid;
    logic                  in_ready;
    logic [DW-1:0]         out_data;
    logic signed [D2W-1:0] out_data2;
    logic                  out_valid;
    logic                  out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    stream_skid_slice #(
        .DATA_WIDTH (DW),
        .DATA2_WIDTH(D2W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_data2 (in_data2),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_data2(out_data2),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] s13(input logic [D2W-1:0] v);
        return {19'b0, v};
    endfunction

    // ---------------- reference model / scoreboard ----------------
    logic [DW+D2W-1:0] exp_q[$];
    int n_pushed = 0;
    int n_popped = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            case (exp_q.size())
                0: begin
                    if (in_valid) begin
                        exp_q.push_back({in_data, in_data2});
                        n_pushed <= n_pushed + 1;
                    end
                end
                1: begin
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_popped <= n_popped + 1;
                    end
                    if (in_valid) begin
                        exp_q.push_back({in_data, in_data2});
                        n_pushed <= n_pushed + 1;
                    end
                end
                default: begin
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_popped <= n_popped + 1;
                    end
                end
            endcase
        end
    end

    logic              prev_hold = 1'b0;
    logic [DW+D2W-1:0] prev_word = '0;

    always @(negedge clk) begin
        check("cmp_out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
        check("cmp_in_ready", {31'b0, in_ready}, {31'b0, exp_q.size() < 2});
        if (exp_q.size() != 0) begin
            check("cmp_out_data", {16'b0, out_data}, {16'b0, exp_q[0][DW+D2W-1:D2W]});
            check("cmp_out_data2", s13(out_data2), s13(exp_q[0][D2W-1:0]));
        end
        if (prev_hold && rst_n)
            check("stall_stable", {3'b0, out_data, out_data2}, {3'b0, prev_word});
        prev_hold <= out_valid && !out_ready && rst_n;
        prev_word <= {out_data, out_data2};
    end

    // ---------------- driver tasks ----------------
    // Inputs change and directed checks are made 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [D2W-1:0] d2);
        in_valid = v;
        in_data  = d;
        in_data2 = d2;
    endtask

    task automatic expect_out(input string name, input logic v, input logic r,
                              input logic [DW-1:0] d, input logic [D2W-1:0] d2);
        check({name, "_valid"}, {31'b0, out_valid}, {31'b0, v});
        check({name, "_ready"}, {31'b0, in_ready}, {31'b0, r});
        if (v) begin
            check({name, "_data"}, {16'b0, out_data}, {16'b0, d});
            check({name, "_data2"}, s13(out_data2), s13(d2));
        end
    endtask

    task automatic drain();
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        repeat (3) step();
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int sent;
        int cycles;
        int push_base;
        logic rdy;

        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0);

        // 1. reset: inputs toggling while held in reset
        for (int i = 0; i < 4; i++) begin
            step();
            drive(1'(i % 2 == 0), 16'(16'h1111 * (i + 1)), 13'(i * 3 - 5));
            out_ready = 1'(i % 2);
            #1;
            check("rst_hold_valid", {31'b0, out_valid}, 32'd0);
            check("rst_hold_ready", {31'b0, in_ready}, 32'd1);
            check("rst_hold_data", {16'b0, out_data}, 32'd0);
            check("rst_hold_data2", s13(out_data2), 32'd0);
        end
        drive(1'b0, '0, '0);
        out_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("rst_rel_valid", {31'b0, out_valid}, 32'd0);
        check("rst_rel_ready", {31'b0, in_ready}, 32'd1);
        check("rst_rel_data", {16'b0, out_data}, 32'd0);
        check("rst_rel_data2", s13(out_data2), 32'd0);

        // 2. back-to-back streaming, one beat per cycle
        out_ready = 1'b1;
        drive(1'b1, 16'h0001, 13'(-4096));
        for (int k = 1; k <= 16; k++) begin
            step();
            expect_out("stream", 1'b1, 1'b1, 16'(k), 13'(-4096 + k - 1));
            if (k < 16)
                drive(1'b1, 16'(k + 1), 13'(-4096 + k));
            else
                drive(1'b0, '0, '0);
        end
        step();
        expect_out("stream_end", 1'b0, 1'b1, '0, '0);

        // 3. backpressure into FULL, then release
        out_ready = 1'b0;
        drive(1'b1, 16'hAAAA, 13'(-1));
        step();
        expect_out("bp_first", 1'b1, 1'b1, 16'hAAAA, 13'(-1));
        drive(1'b1, 16'h5555, 13'(4095));
        step();
        expect_out("bp_full", 1'b1, 1'b0, 16'hAAAA, 13'(-1));
        drive(1'b1, 16'h1234, 13'(77));    // offered while full, must be ignored
        step();
        expect_out("bp_ignore", 1'b1, 1'b0, 16'hAAAA, 13'(-1));
        drive(1'b0, '0, '0);
        step();
        expect_out("bp_hold", 1'b1, 1'b0, 16'hAAAA, 13'(-1));
        out_ready = 1'b1;
        step();
        expect_out("bp_second", 1'b1, 1'b1, 16'h5555, 13'(4095));
        step();
        expect_out("bp_empty", 1'b0, 1'b1, '0, '0);

        // 4. in_fire and out_fire together while ONE
        drive(1'b1, 16'h0101, 13'(100));
        step();
        expect_out("simul_a", 1'b1, 1'b1, 16'h0101, 13'(100));
        drive(1'b1, 16'h0202, 13'(-100));
        step();
        expect_out("simul_b", 1'b1, 1'b1, 16'h0202, 13'(-100));
        drive(1'b0, '0, '0);
        step();
        expect_out("simul_end", 1'b0, 1'b1, '0, '0);

        // 5. random valid/ready; the source holds a beat until it is taken
        push_base = n_pushed;
        sent      = 0;
        cycles    = 0;
        drive(1'b0, '0, '0);
        while (sent < RAND_BEATS && cycles < 60000) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #2;
            cycles++;
            if (in_valid && rdy) sent++;
            if (!in_valid || rdy) begin
                if (sent < RAND_BEATS)
                    drive(1'($urandom_range(0, 3) != 0), 16'($urandom_range(0, 65535)),
                          13'($urandom_range(0, 8191)));
                else
                    drive(1'b0, '0, '0);
            end
            out_ready = 1'($urandom_range(0, 3) != 0);
        end
        check("rand_budget", {31'b0, sent >= RAND_BEATS}, 32'd1);
        drain();
        check("rand_pushed", 32'(n_pushed - push_base), 32'(RAND_BEATS));
        check("no_loss_dup", 32'(n_pushed), 32'(n_popped));

        // 6. asynchronous reset while FULL
        out_ready = 1'b0;
        drive(1'b1, 16'h0C0C, 13'(7));
        step();
        drive(1'b1, 16'h0D0D, 13'(-7));
        step();
        expect_out("pre_rst_full", 1'b1, 1'b0, 16'h0C0C, 13'(7));
        drive(1'b0, '0, '0);
        #1;
        rst_n = 1'b0;
        #1;
        expect_out("async_rst", 1'b0, 1'b1, '0, '0);
        check("async_rst_data", {16'b0, out_data}, 32'd0);
        check("async_rst_data2", s13(out_data2), 32'd0);
        out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
        expect_out("post_rst_idle", 1'b0, 1'b1, '0, '0);
        drive(1'b1, 16'h0BEE, 13'(-2));
        step();
        expect_out("post_rst_first", 1'b1, 1'b1, 16'h0BEE, 13'(-2));
        drive(1'b0, '0, '0);
        step();
        expect_out("post_rst_end", 1'b0, 1'b1, '0, '0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
